dmem_responder: RTL

Memory-side responder for the pipeline's memory stage: accepts one load/store request at a time over a valid/ready handshake, holds it for a fixed access latency, then commits the store or returns the sign/zero-extended load data with a one-cycle response pulse. It replaces the single-cycle data memory behind the memory stage. The memory stage stalls on `req_ready` low and captures `rsp_rdata` on `rsp_valid`.

---
 rtl/dmem_pkg.sv | 36 +++
 rtl/dmem_lane_align.sv | 53 +++++
 rtl/dmem_responder.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/dmem_pkg.sv
// Shared encodings, FSM states and address-check helpers for the data-memory responder.
package dmem_pkg;

   localparam logic [2:0] SZ_B  = 3'b000;
   localparam logic [2:0] SZ_H  = 3'b001;
   localparam logic [2:0] SZ_W  = 3'b010;
   localparam logic [2:0] SZ_BU = 3'b100;
   localparam logic [2:0] SZ_HU = 3'b101;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   function automatic logic is_misaligned(input logic [2:0] size, input logic [1:0] addr);
      logic mis;
      case (size[1:0])
         2'b01:   mis = addr[0];
         2'b10:   mis = (addr != 2'b00);
         default: mis = 1'b0;
      endcase
      return mis;
   endfunction

   function automatic logic is_bad_size(input logic [2:0] size, input logic we);
      logic bad;
      case (size)
         SZ_B, SZ_H, SZ_W: bad = 1'b0;
         SZ_BU, SZ_HU:     bad = we;
         default:          bad = 1'b1;
      endcase
      return bad;
   endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering: store byte enables / replicated write data, and load extract + extend.
module dmem_lane_align
   import dmem_pkg::*;
(
   input  logic [2:0]  size,
   input  logic [1:0]  addr_lo,
   input  logic [31:0] wdata,
   input  logic [31:0] rword,
   output logic [3:0]  wbe,
   output logic [31:0] wlane,
   output logic [31:0] rdata
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      wbe   = 4'b0000;
      wlane = 32'h0000_0000;
      case (size[1:0])
         2'b00: begin
            wbe   = 4'b0001 << addr_lo;
            wlane = {4{wdata[7:0]}};
         end
         2'b01: begin
            wbe   = addr_lo[1] ? 4'b1100 : 4'b0011;
            wlane = {2{wdata[15:0]}};
         end
         2'b10: begin
            wbe   = 4'b1111;
            wlane = wdata;
         end
         default: begin
            wbe   = 4'b0000;
            wlane = 32'h0000_0000;
         end
      endcase
   end

   always_comb begin
      byte_sel = rword[{addr_lo, 3'b000} +: 8];
      half_sel = addr_lo[1] ? rword[31:16] : rword[15:0];
      case (size)
         SZ_B:    rdata = {{24{byte_sel[7]}}, byte_sel};
         SZ_BU:   rdata = {24'h00_0000, byte_sel};
         SZ_H:    rdata = {{16{half_sel[15]}}, half_sel};
         SZ_HU:   rdata = {16'h0000, half_sel};
         SZ_W:    rdata = rword;
         default: rdata = 32'h0000_0000;
      endcase
   end

endmodule

// File: rtl/dmem_responder.sv
// Fixed-latency load/store responder: one request in flight, memory access on the edge
// entering RESP, single-cycle response pulse.
module dmem_responder
   import dmem_pkg::*;
#(
   parameter int DEPTH_WORDS = 256,
   parameter int LATENCY     = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [2:0]  req_size,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err,
   output logic        busy
);

   localparam int            IW       = $clog2(DEPTH_WORDS);
   localparam int            CW       = $clog2(LATENCY + 1);
   localparam logic [CW-1:0] CNT_LOAD = CW'((LATENCY > 1) ? (LATENCY - 2) : 0);
   localparam bit            LAT1     = (LATENCY == 1);

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          we_q, we_d;
   logic [2:0]    size_q, size_d;
   logic [31:0]   addr_q, addr_d;
   logic [31:0]   wdata_q, wdata_d;
   logic          rsp_valid_q, rsp_valid_d;
   logic [31:0]   rsp_rdata_q, rsp_rdata_d;
   logic          rsp_err_q, rsp_err_d;

   logic [31:0]   mem_array [DEPTH_WORDS];

   logic          accept, enter_resp, acc_we, acc_err, mem_wr;
   logic [2:0]    acc_size;
   logic [31:0]   acc_addr, acc_wdata, rword, load_data, wlane;
   logic [3:0]    wbe;
   logic [IW-1:0] widx;

   assign req_ready = (state_q == ST_IDLE) || (state_q == ST_RESP);
   assign busy      = (state_q == ST_WAIT);
   assign accept    = req_valid && req_ready;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      we_d    = we_q;
      size_d  = size_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      case (state_q)
         ST_IDLE, ST_RESP: begin
            if (accept) begin
               we_d    = req_we;
               size_d  = req_size;
               addr_d  = req_addr;
               wdata_d = req_wdata;
               if (LAT1) begin
                  state_d = ST_RESP;
               end else begin
                  state_d = ST_WAIT;
                  cnt_d   = CNT_LOAD;
               end
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_WAIT: begin
            if (cnt_q == {CW{1'b0}}) begin
               state_d = ST_RESP;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // With single-cycle latency the access uses the request being accepted this cycle.
   assign acc_we     = LAT1 ? req_we    : we_q;
   assign acc_size   = LAT1 ? req_size  : size_q;
   assign acc_addr   = LAT1 ? req_addr  : addr_q;
   assign acc_wdata  = LAT1 ? req_wdata : wdata_q;
   assign enter_resp = (state_d == ST_RESP);
   assign widx       = acc_addr[IW+1:2];
   assign rword      = mem_array[widx];
   assign acc_err    = is_bad_size(acc_size, acc_we) || is_misaligned(acc_size, acc_addr[1:0])
                       || (|acc_addr[31:IW+2]);
   assign mem_wr     = enter_resp && acc_we && !acc_err;

   dmem_lane_align u_align (
      .size    (acc_size),
      .addr_lo (acc_addr[1:0]),
      .wdata   (acc_wdata),
      .rword   (rword),
      .wbe     (wbe),
      .wlane   (wlane),
      .rdata   (load_data)
   );

   always_comb begin
      rsp_valid_d = enter_resp;
      rsp_err_d   = enter_resp && acc_err;
      if (enter_resp && !acc_we && !acc_err) begin
         rsp_rdata_d = load_data;
      end else begin
         rsp_rdata_d = 32'h0000_0000;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         cnt_q       <= {CW{1'b0}};
         we_q        <= 1'b0;
         size_q      <= 3'b000;
         addr_q      <= 32'h0000_0000;
         wdata_q     <= 32'h0000_0000;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= 32'h0000_0000;
         rsp_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         we_q        <= we_d;
         size_q      <= size_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_rdata_q <= rsp_rdata_d;
         rsp_err_q   <= rsp_err_d;
      end
   end

   always_ff @(posedge clk) begin
      if (mem_wr) begin
         for (int i = 0; i < 4; i++) begin
            if (wbe[i]) begin
               mem_array[widx][8*i +: 8] <= wlane[8*i +: 8];
            end
         end
      end
   end

   assign rsp_valid = rsp_valid_q;
   assign rsp_rdata = rsp_rdata_q;
   assign rsp_err   = rsp_err_q;

endmodule
